// File: rtl/rtc_pkg.sv
// Shared types for the RTC set sequencer: FSM states, datetime field offsets, byte mapping.
package rtc_pkg;

  typedef enum logic [2:0] {IDLE, CHECK, WRITE, GAP, RESUME, DONE} state_t;

  localparam logic [2:0] RTC_ADDR_RESUME = 3'd7;

  // Byte offsets inside the 56-bit {YY,MO,DD,WD,HH,MI,SS} datetime
  localparam int SS_LSB = 0;
  localparam int MI_LSB = 8;
  localparam int HH_LSB = 16;
  localparam int WD_LSB = 24;
  localparam int DD_LSB = 32;
  localparam int MO_LSB = 40;
  localparam int YY_LSB = 48;

  function automatic logic [7:0] rtc_byte(input logic [55:0] dt, input logic [2:0] idx,
                                          input logic st_bit, input logic vbaten);
    logic [7:0] b;
    b = '0;
    case (idx)
      3'd0:    b = {st_bit, dt[SS_LSB +: 7]};
      3'd1:    b = {1'b0, dt[MI_LSB +: 7]};
      3'd2:    b = {2'b00, dt[HH_LSB +: 6]};
      3'd3:    b = {4'b0000, vbaten, dt[WD_LSB +: 3]};
      3'd4:    b = dt[DD_LSB +: 8];
      3'd5:    b = {3'b000, dt[MO_LSB +: 5]};
      3'd6:    b = dt[YY_LSB +: 8];
      default: b = '0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/rtc_bcd_check.sv
// Combinational range check of a BCD datetime; ok=1 when every field is a legal value.
module rtc_bcd_check
  import rtc_pkg::*;
(
  input  logic [55:0] datetime,
  output logic        ok
);

  logic       nib_ok;
  logic [7:0] ss, mi, hh, wd, dd, mo;

  always_comb begin
    nib_ok = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (datetime[i*4 +: 4] > 4'd9) nib_ok = 1'b0;
    end
  end

  assign ss = datetime[SS_LSB +: 8];
  assign mi = datetime[MI_LSB +: 8];
  assign hh = datetime[HH_LSB +: 8];
  assign wd = datetime[WD_LSB +: 8];
  assign dd = datetime[DD_LSB +: 8];
  assign mo = datetime[MO_LSB +: 8];

  // Nibbles are known decimal here, so plain byte compares act as BCD compares
  assign ok = nib_ok
            && (ss <= 8'h59) && (mi <= 8'h59) && (hh <= 8'h23)
            && (wd >= 8'h01) && (wd <= 8'h07)
            && (dd >= 8'h01) && (dd <= 8'h31)
            && (mo >= 8'h01) && (mo <= 8'h12);

endmodule

// File: rtl/rtc_set_sequencer.sv
// Range-checks a CPU datetime, writes it to the RTC core as 7 paced byte writes plus a resume
// write, and snapshots the running time on core ticks while idle.
module rtc_set_sequencer
  import rtc_pkg::*;
#(
  parameter int   WR_GAP = 262144,
  parameter logic ST_BIT = 1'b1,
  parameter logic VBATEN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        set_req,
  input  logic [55:0] set_datetime,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [55:0] time_o,
  output logic        time_valid,
  output logic        rtc_wr,
  output logic [2:0]  rtc_addr,
  output logic [7:0]  rtc_data,
  input  logic        rtc_tick,
  input  logic [55:0] rtc_datetime
);

  localparam int CW = $clog2(WR_GAP + 1);

  state_t        state, next;
  logic [55:0]   shadow;
  logic [CW-1:0] gap_cnt;
  logic [2:0]    idx;
  logic [2:0]    wr_idx;
  logic          check_ok;
  logic          err_q;

  rtc_bcd_check u_check (
    .datetime (shadow),
    .ok       (check_ok)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      IDLE:    if (set_req) next = CHECK;
      CHECK:   next = check_ok ? WRITE : DONE;
      WRITE:   next = GAP;
      GAP:     if (gap_cnt == '0) next = (idx == 3'd6) ? RESUME : WRITE;
      RESUME:  next = DONE;
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
  end

  // Index of the byte about to be written when entering WRITE
  assign wr_idx = (state == CHECK) ? 3'd0 : idx + 3'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow     <= '0;
      gap_cnt    <= '0;
      idx        <= '0;
      err_q      <= 1'b0;
      rtc_addr   <= RTC_ADDR_RESUME;
      rtc_data   <= '0;
      time_o     <= '0;
      time_valid <= 1'b0;
    end else begin
      if (state == IDLE && set_req) shadow <= set_datetime;

      if (state == CHECK) err_q <= ~check_ok;

      if (state == WRITE)                    gap_cnt <= CW'(WR_GAP - 1);
      else if (state == GAP && gap_cnt != '0) gap_cnt <= gap_cnt - CW'(1);

      if (next == WRITE) begin
        idx      <= wr_idx;
        rtc_addr <= wr_idx;
        rtc_data <= rtc_byte(shadow, wr_idx, ST_BIT, VBATEN);
      end else if (next == RESUME) begin
        rtc_addr <= RTC_ADDR_RESUME;
        rtc_data <= '0;
      end

      // Snapshots only while idle so time_o never mixes with a half-written set
      if (rtc_tick && state == IDLE) begin
        time_o     <= rtc_datetime;
        time_valid <= 1'b1;
      end
    end
  end

  assign busy   = (state != IDLE);
  assign done   = (state == DONE);
  assign error  = (state == DONE) && err_q;
  assign rtc_wr = (state == WRITE) || (state == RESUME);

endmodule

// File: tb/tb_rtc_set_sequencer.sv
// Scoreboard bench for rtc_set_sequencer with a small WR_GAP and a spec-level reference model.
module tb_rtc_set_sequencer;

  localparam int GAP = 4;
  localparam int SP  = GAP + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        set_req = 1'b0;
  logic [55:0] set_datetime = '0;
  logic        rtc_tick = 1'b0;
  logic [55:0] rtc_datetime = '0;
  logic        busy, done, error, time_valid, rtc_wr;
  logic [55:0] time_o;
  logic [2:0]  rtc_addr;
  logic [7:0]  rtc_data;

  rtc_set_sequencer #(.WR_GAP(GAP)) dut (
    .clk          (clk),
    .reset        (reset),
    .set_req      (set_req),
    .set_datetime (set_datetime),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .time_o       (time_o),
    .time_valid   (time_valid),
    .rtc_wr       (rtc_wr),
    .rtc_addr     (rtc_addr),
    .rtc_data     (rtc_data),
    .rtc_tick     (rtc_tick),
    .rtc_datetime (rtc_datetime)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [2:0] addr; logic [7:0] data; int at; } wr_t;
  typedef struct { logic err; int at; } dn_t;

  wr_t         wq[$];
  dn_t         dq[$];
  int          errors = 0;
  int          checks = 0;
  logic [55:0] exp_time = '0;
  int          last_t = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic int bcd_val(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [7:0] to_bcd(input int n);
    return 8'((n / 10) * 16 + (n % 10));
  endfunction

  function automatic bit ref_ok(input logic [55:0] dt);
    int v[7];
    logic [7:0] b;
    for (int i = 0; i < 7; i++) begin
      b = dt[i*8 +: 8];
      if (b[7:4] > 4'd9 || b[3:0] > 4'd9) return 1'b0;
      v[i] = bcd_val(b);
    end
    return (v[0] <= 59) && (v[1] <= 59) && (v[2] <= 23) && (v[3] >= 1) && (v[3] <= 7)
        && (v[4] >= 1) && (v[4] <= 31) && (v[5] >= 1) && (v[5] <= 12);
  endfunction

  function automatic logic [7:0] ref_byte(input logic [55:0] dt, input int i);
    case (i)
      0:       return (dt[7:0]   & 8'h7F) | 8'h80;
      1:       return  dt[15:8]  & 8'h7F;
      2:       return  dt[23:16] & 8'h3F;
      3:       return (dt[31:24] & 8'h07) | 8'h08;
      4:       return  dt[39:32];
      5:       return  dt[47:40] & 8'h1F;
      6:       return  dt[55:48];
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [55:0] make_valid();
    return {to_bcd(int'($urandom_range(99))), to_bcd(int'($urandom_range(12, 1))),
            to_bcd(int'($urandom_range(31, 1))), to_bcd(int'($urandom_range(7, 1))),
            to_bcd(int'($urandom_range(23))), to_bcd(int'($urandom_range(59))),
            to_bcd(int'($urandom_range(59)))};
  endfunction

  task automatic monitor();
    logic prev_wr = 1'b0;
    wr_t  w;
    dn_t  d;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_wr = 1'b0;
      end else begin
        if (rtc_wr) begin
          chk("wr_back_to_back", {63'b0, prev_wr}, 64'd0);
          if (wq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_wr: got pulse addr=%0h data=%0h required none", rtc_addr, rtc_data);
          end else begin
            w = wq.pop_front();
            chk("wr_addr", 64'(rtc_addr), 64'(w.addr));
            chk("wr_data", 64'(rtc_data), 64'(w.data));
            chk("wr_cycle", 64'(cyc), 64'(w.at));
          end
        end
        if (done) begin
          if (dq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done: got done error=%0b required none", error);
          end else begin
            d = dq.pop_front();
            chk("done_error", 64'(error), 64'(d.err));
            chk("done_cycle", 64'(cyc), 64'(d.at));
          end
        end
        prev_wr = rtc_wr;
      end
    end
  endtask

  task automatic issue(input logic [55:0] dt, input bit with_tick);
    logic [55:0] tv;
    @(posedge clk); #1;
    set_req = 1'b1;
    set_datetime = dt;
    last_t = cyc;
    if (ref_ok(dt)) begin
      for (int i = 0; i < 8; i++) wq.push_back('{addr: 3'(i), data: ref_byte(dt, i), at: last_t + 2 + SP*i});
      dq.push_back('{err: 1'b0, at: last_t + 2 + SP*7 + 1});
    end else begin
      dq.push_back('{err: 1'b1, at: last_t + 2});
    end
    if (with_tick) begin
      tv = {$urandom(), 24'($urandom())};
      rtc_tick = 1'b1;
      rtc_datetime = tv;
      exp_time = tv;
    end
    @(posedge clk); #1;
    set_req = 1'b0;
    rtc_tick = 1'b0;
    if (with_tick) begin
      chk("tick_with_set_time", 64'(time_o), 64'(exp_time));
      chk("tick_with_set_valid", 64'(time_valid), 64'd1);
    end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (dq.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (dq.size() != 0) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got %0d pending done required 0", name, dq.size());
      dq.delete();
      wq.delete();
    end
    chk({name, "_pending_wr"}, 64'(wq.size()), 64'd0);
    chk({name, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  logic [55:0] tbl[6];

  initial begin
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_wr", 64'(rtc_wr), 64'd0);
    chk("rst_addr", 64'(rtc_addr), 64'd7);
    chk("rst_data", 64'(rtc_data), 64'd0);
    chk("rst_time", 64'(time_o), 64'd0);
    chk("rst_valid", 64'(time_valid), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Nominal set, bad hour, bad seconds nibble, weekday zero
    issue(56'h24_06_15_06_13_45_30, 1'b0); wait_done("t1");
    issue(56'h24_06_15_06_24_45_30, 1'b0); wait_done("t2");
    issue(56'h24_06_15_06_13_45_5A, 1'b0); wait_done("t3a");
    issue(56'h24_06_15_00_13_45_30, 1'b0); wait_done("t3b");

    // Tick while idle captures; tick while busy is dropped
    @(posedge clk); #1;
    rtc_tick = 1'b1; rtc_datetime = 56'h24_06_15_06_12_00_00; exp_time = 56'h24_06_15_06_12_00_00;
    @(posedge clk); #1;
    rtc_tick = 1'b0;
    chk("t4_time", 64'(time_o), 64'(exp_time));
    chk("t4_valid", 64'(time_valid), 64'd1);
    issue(make_valid(), 1'b0);
    repeat (6) @(posedge clk); #1;
    rtc_tick = 1'b1; rtc_datetime = 56'h99_12_31_07_23_59_59;
    @(posedge clk); #1;
    rtc_tick = 1'b0;
    wait_done("t4b");
    chk("t4_busy_tick_dropped", 64'(time_o), 64'(exp_time));

    // Second request during GAP is ignored
    issue(56'h25_01_02_03_04_05_06, 1'b0);
    repeat (8) @(posedge clk); #1;
    set_req = 1'b1; set_datetime = 56'h11_11_11_01_11_11_11;
    @(posedge clk); #1;
    set_req = 1'b0;
    wait_done("t5");

    // Reset in the gap after byte 3, then a fresh full sequence
    issue(56'h24_06_15_06_13_45_30, 1'b0);
    repeat (18) @(posedge clk); #1;
    chk("t6_remaining_wr", 64'(wq.size()), 64'd4);
    reset = 1'b1;
    wq.delete();
    dq.delete();
    #1;
    chk("t6_wr", 64'(rtc_wr), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_addr", 64'(rtc_addr), 64'd7);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_time = '0;
    issue(56'h24_06_15_06_13_45_30, 1'b0); wait_done("t6b");

    // Boundary values and random traffic
    tbl[0] = 56'h99_12_31_07_23_59_59;
    tbl[1] = 56'h00_01_01_01_00_00_00;
    tbl[2] = 56'h24_13_15_06_13_45_30;
    tbl[3] = 56'h24_06_00_06_13_45_30;
    tbl[4] = 56'h24_06_32_06_13_45_30;
    tbl[5] = 56'h24_06_15_08_13_60_30;
    for (int k = 0; k < 6; k++) begin
      issue(tbl[k], 1'b0); wait_done("bound");
    end
    for (int k = 0; k < 8; k++) begin
      issue(($urandom_range(1) == 1) ? make_valid() : {$urandom(), 24'($urandom())},
            $urandom_range(1) == 1);
      wait_done("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
